// File: rtl/datapath_pkg.sv
// Shared encodings, widths and state/class types for the 16-bit datapath controller.
package datapath_pkg;

  localparam int WIDTH  = 16;
  localparam int REGSEL = 3;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  typedef enum logic [2:0] {
    WAIT,
    DECODE,
    GETA,
    GETB,
    ALU,
    WREG,
    WIMM
  } state_t;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ADD,
    CLS_CMP,
    CLS_AND,
    CLS_MVN
  } instr_class_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational split of the latched instruction word into register fields,
// sign-extended immediate and an instruction class.
module instr_decoder
  import datapath_pkg::*;
#(
  parameter int WIDTH  = datapath_pkg::WIDTH,
  parameter int REGSEL = datapath_pkg::REGSEL
) (
  input  logic [WIDTH-1:0]  ir,
  output logic [1:0]        op,
  output logic [REGSEL-1:0] rn,
  output logic [REGSEL-1:0] rd,
  output logic [REGSEL-1:0] rm,
  output logic [1:0]        sh,
  output logic [WIDTH-1:0]  imm_sext,
  output instr_class_t      cls,
  output logic              illegal
);

  logic [2:0] opcode;

  assign opcode   = ir[15:13];
  assign op       = ir[12:11];
  assign rn       = ir[10:8];
  assign rd       = ir[7:5];
  assign sh       = ir[4:3];
  assign rm       = ir[2:0];
  assign imm_sext = {{(WIDTH-8){ir[7]}}, ir[7:0]};

  // Only the six listed opcode/op pairs are legal; everything else falls to CLS_ILLEGAL.
  always_comb begin
    cls = CLS_ILLEGAL;
    case (opcode)
      OPC_MOV: begin
        if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
        else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
      end
      OPC_ALU: begin
        case (op)
          ALU_ADD: cls = CLS_ADD;
          ALU_CMP: cls = CLS_CMP;
          ALU_AND: cls = CLS_AND;
          ALU_MVN: cls = CLS_MVN;
          default: cls = CLS_ILLEGAL;
        endcase
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/datapath_controller.sv
// Moore controller: latches one instruction under the s/w handshake and
// sequences the datapath strobes; every output decodes from state and IR.
module datapath_controller
  import datapath_pkg::*;
#(
  parameter int WIDTH  = datapath_pkg::WIDTH,
  parameter int REGSEL = datapath_pkg::REGSEL
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s,
  input  logic [WIDTH-1:0]  instr,
  output logic              w,
  output logic              done,
  output logic              err,
  output logic [REGSEL-1:0] readnum,
  output logic [REGSEL-1:0] writenum,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              write,
  output logic              vsel,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [WIDTH-1:0]  datapath_in
);

  state_t            state, state_next;
  logic [WIDTH-1:0]  ir;
  logic [1:0]        op;
  logic [REGSEL-1:0] rn, rd, rm;
  logic [1:0]        sh;
  logic [WIDTH-1:0]  imm_sext;
  instr_class_t      cls;
  logic              illegal;

  instr_decoder #(
    .WIDTH  (WIDTH),
    .REGSEL (REGSEL)
  ) u_decoder (
    .ir       (ir),
    .op       (op),
    .rn       (rn),
    .rd       (rd),
    .rm       (rm),
    .sh       (sh),
    .imm_sext (imm_sext),
    .cls      (cls),
    .illegal  (illegal)
  );

  // IR only loads on the accept edge, so s pulses mid-instruction cannot disturb it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WAIT;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == WAIT && s) ir <= instr;
    end
  end

  always_comb begin
    state_next  = state;
    w           = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    readnum     = '0;
    writenum    = '0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    write       = 1'b0;
    vsel        = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    shift       = 2'b00;
    ALUop       = 2'b00;
    datapath_in = '0;

    case (state)
      WAIT: begin
        w = 1'b1;
        if (s) state_next = DECODE;
      end
      DECODE: begin
        if (illegal) begin
          err        = 1'b1;
          state_next = WAIT;
        end else if (cls == CLS_MOV_IMM) begin
          state_next = WIMM;
        end else if (cls == CLS_MOV_REG || cls == CLS_MVN) begin
          state_next = GETB;
        end else begin
          state_next = GETA;
        end
      end
      GETA: begin
        readnum    = rn;
        loada      = 1'b1;
        state_next = GETB;
      end
      GETB: begin
        readnum    = rm;
        loadb      = 1'b1;
        state_next = ALU;
      end
      // MOV-reg passes B through the adder with a zeroed A operand.
      ALU: begin
        shift = sh;
        if (cls == CLS_MOV_REG) begin
          asel  = 1'b1;
          ALUop = ALU_ADD;
        end else begin
          ALUop = op;
        end
        if (cls == CLS_CMP) begin
          loads      = 1'b1;
          done       = 1'b1;
          state_next = WAIT;
        end else begin
          loadc      = 1'b1;
          state_next = WREG;
        end
      end
      WREG: begin
        writenum   = rd;
        write      = 1'b1;
        done       = 1'b1;
        state_next = WAIT;
      end
      WIMM: begin
        datapath_in = imm_sext;
        vsel        = 1'b1;
        writenum    = rn;
        write       = 1'b1;
        done        = 1'b1;
        state_next  = WAIT;
      end
      default: state_next = WAIT;
    endcase
  end

endmodule
